// File: rtl/aud_pkg.sv
// aud_pkg: shared state encoding and channel constants for the multi-channel I2S recorder.
// Revision: 1.0
`default_nettype none

package aud_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_SHIFT = 3'd2,
    S_PAUSE = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

`default_nettype wire

// File: rtl/aud_recorder_mc_if.sv
// aud_recorder_mc_if: SRAM write port of the recorder (strobe, word address, sample, channel).
// Revision: 1.0
`default_nettype none

interface aud_recorder_mc_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              o_we;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_ch;

  modport master (output o_we, output o_address, output o_data, output o_ch);
  modport slave  (input  o_we, input  o_address, input  o_data, input  o_ch);
endinterface

`default_nettype wire

// File: rtl/i2s_deser.sv
// i2s_deser: LRC edge detect, bit counter and MSB-first shift register for one I2S slot at a time.
// Revision: 1.0
`default_nettype none

module i2s_deser
  import aud_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_align,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic              o_slot_start,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_ch,
  output logic              o_short_err
);

  localparam int              c_cw   = $clog2(DATA_W);
  localparam logic [c_cw-1:0] c_last = c_cw'(DATA_W - 1);

  logic              r_lrc_q;
  logic              r_active;
  logic              r_ch;
  logic [c_cw-1:0]   r_cnt;
  logic [DATA_W-2:0] r_shift;

  logic w_edge;
  logic w_take;
  logic w_last;
  logic w_start;

  assign w_edge  = (i_lrc != r_lrc_q);
  assign w_take  = i_en && r_active;
  // The bit present on an edge cycle still belongs to the old slot, so exact-length slots complete.
  assign w_last  = w_take && (r_cnt == c_last);
  assign w_start = i_en && w_edge && (!i_lrc || !i_align);
  assign o_slot_start = w_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lrc_q      <= 1'b0;
      r_active     <= 1'b0;
      r_ch         <= CH_L;
      r_cnt        <= '0;
      r_shift      <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
      o_word_ch    <= CH_L;
      o_short_err  <= 1'b0;
    end else begin
      r_lrc_q      <= i_lrc;
      o_word_valid <= w_last;
      o_short_err  <= w_take && w_edge && !w_last;
      if (w_last) begin
        o_word    <= {r_shift, i_data};
        o_word_ch <= r_ch;
      end
      if (!i_en) begin
        r_active <= 1'b0;
      end else if (w_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_ch     <= i_lrc;
      end else if (w_last || w_edge) begin
        r_active <= 1'b0;
      end else if (w_take) begin
        r_shift <= {r_shift[DATA_W-3:0], i_data};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aud_recorder_mc.sv
// aud_recorder_mc: multi-channel I2S capture engine with address window, wrap/stop-on-full and length readback.
// Revision: 1.0
`default_nettype none

module aud_recorder_mc
  import aud_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0,
  parameter int LAST_ADDR = 2**20 - 1,
  parameter int LOOP      = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_lrc,
  input  logic                   i_data,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_stop,
  aud_recorder_mc_if.master      o_wr,
  output logic                   o_busy,
  output logic                   o_full,
  output logic                   o_err,
  output logic [ADDR_W:0]        o_len
);

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W:0]   c_win  = (ADDR_W+1)'(LAST_ADDR - BASE_ADDR + 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic              r_err;

  logic              w_run;
  logic              w_align;
  logic              w_slot_start;
  logic              w_we;
  logic [DATA_W-1:0] w_word;
  logic              w_word_ch;
  logic              w_short;
  logic              w_at_last;

  // Pause/stop disable the deserialiser in the same cycle so a partial word is dropped at once.
  assign w_run     = ((r_state == S_ARM) || (r_state == S_SHIFT)) && !i_stop && !i_pause;
  assign w_align   = (r_state == S_ARM) || (NUM_CH == 1);
  assign w_at_last = (r_addr == c_last);

  i2s_deser #(
    .DATA_W (DATA_W)
  ) u_deser (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (w_run),
    .i_align      (w_align),
    .i_lrc        (i_lrc),
    .i_data       (i_data),
    .o_slot_start (w_slot_start),
    .o_word_valid (w_we),
    .o_word       (w_word),
    .o_word_ch    (w_word_ch),
    .o_short_err  (w_short)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= c_base;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_we) begin
        if (!w_at_last) begin
          r_addr <= r_addr + 1'b1;
        end else if (LOOP != 0) begin
          r_addr <= c_base;
        end
        if (r_len != c_win) begin
          r_len <= r_len + 1'b1;
        end
      end
      if (w_short) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop && !i_pause) begin
            r_state <= S_ARM;
            r_addr  <= c_base;
            r_len   <= '0;
            r_err   <= 1'b0;
          end
        end
        S_ARM: begin
          if (i_stop)            r_state <= S_IDLE;
          else if (i_pause)      r_state <= S_PAUSE;
          else if (w_slot_start) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (i_stop)                                r_state <= S_IDLE;
          else if (w_we && w_at_last && (LOOP == 0)) r_state <= S_FULL;
          else if (i_pause)                          r_state <= S_PAUSE;
        end
        S_PAUSE: begin
          if (i_stop)                   r_state <= S_IDLE;
          else if (i_start && !i_pause) r_state <= S_ARM;
        end
        S_FULL: begin
          if (i_stop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wr.o_we      = w_we;
  assign o_wr.o_address = r_addr;
  assign o_wr.o_data    = w_word;
  assign o_wr.o_ch      = w_word_ch;

  assign o_busy = (r_state == S_ARM) || (r_state == S_SHIFT) || (r_state == S_PAUSE);
  assign o_full = (r_state == S_FULL);
  assign o_err  = r_err;
  assign o_len  = r_len;

endmodule

`default_nettype wire

// File: tb/tb_aud_recorder_mc.sv
// tb_aud_recorder_mc: directed scenarios on three recorder configurations sharing one I2S stream.
// Revision: 1.0
`default_nettype none

module tb_aud_recorder_mc;

  logic clk = 1'b0;
  logic rst, lrc, data, start, pause, stop;
  always #5 clk = ~clk;

  aud_recorder_mc_if #(.ADDR_W(20), .DATA_W(16)) wa ();
  aud_recorder_mc_if #(.ADDR_W(20), .DATA_W(16)) wb ();
  aud_recorder_mc_if #(.ADDR_W(20), .DATA_W(16)) wc ();

  logic a_busy, a_full, a_err, b_busy, b_full, b_err, c_busy, c_full, c_err;
  logic [20:0] a_len, b_len, c_len;

  aud_recorder_mc #(.DATA_W(16), .NUM_CH(2), .ADDR_W(20), .BASE_ADDR(0), .LAST_ADDR(1048575), .LOOP(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(data), .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_wr(wa), .o_busy(a_busy), .o_full(a_full), .o_err(a_err), .o_len(a_len));
  aud_recorder_mc #(.DATA_W(16), .NUM_CH(1), .ADDR_W(20), .BASE_ADDR(4), .LAST_ADDR(7), .LOOP(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(data), .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_wr(wb), .o_busy(b_busy), .o_full(b_full), .o_err(b_err), .o_len(b_len));
  aud_recorder_mc #(.DATA_W(16), .NUM_CH(1), .ADDR_W(20), .BASE_ADDR(4), .LAST_ADDR(7), .LOOP(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(data), .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_wr(wc), .o_busy(c_busy), .o_full(c_full), .o_err(c_err), .o_len(c_len));

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
    logic        c;
  } wr_t;

  wr_t qa[$], qb[$], qc[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (wa.o_we === 1'b1) qa.push_back({wa.o_address, wa.o_data, wa.o_ch});
    if (wb.o_we === 1'b1) qb.push_back({wb.o_address, wb.o_data, wb.o_ch});
    if (wc.o_we === 1'b1) qc.push_back({wc.o_address, wc.o_data, wc.o_ch});
  endtask

  // Cycle 0 of a slot carries the LRC change; the MSB follows one cycle later.
  task automatic send_slot(input logic l, input logic [15:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      lrc  = l;
      data = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
      tick();
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic idle_right(input int n);
    lrc = 1'b1; data = 1'b0;
    repeat (n) tick();
  endtask

  task automatic go();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic clear_logs();
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; lrc = 1'b0; data = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (3) tick();
    checks++; if (wa.o_we !== 1'b0)      begin errors++; $display("FAIL rst_we: got %b want 0", wa.o_we); end
    checks++; if (wa.o_address !== 20'd0) begin errors++; $display("FAIL rst_addr_a: got %h want 0", wa.o_address); end
    checks++; if (wb.o_address !== 20'd4) begin errors++; $display("FAIL rst_addr_b: got %h want 4", wb.o_address); end
    checks++; if ({a_busy, a_full, a_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {a_busy, a_full, a_err}); end
    checks++; if (a_len !== 21'd0 || wa.o_data !== 16'd0) begin errors++; $display("FAIL rst_len_data: got len=%0d data=%h want 0/0", a_len, wa.o_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_capture();
    wr_t exp, got;
    clear_logs();
    idle_right(4);
    go();
    for (int f = 0; f < 3; f++) send_frame(16'hA5C3, 16'h1234);
    checks++; if (qa.size() !== 6) begin errors++; $display("FAIL basic_count: got %0d want 6", qa.size()); end
    for (int i = 0; i < 6; i++) begin
      exp = {20'(i), (i % 2 == 0) ? 16'hA5C3 : 16'h1234, 1'(i % 2)};
      got = (i < qa.size()) ? qa[i] : '1;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_wr%0d: got a=%h d=%h c=%b want a=%h d=%h c=%b", i, got.a, got.d, got.c, exp.a, exp.d, exp.c);
      end
    end
    checks++; if (a_len !== 21'd6 || a_busy !== 1'b1) begin errors++; $display("FAIL basic_len: got len=%0d busy=%b want 6/1", a_len, a_busy); end
    halt();
    checks++; if (a_busy !== 1'b0 || wa.o_address !== 20'd6 || a_len !== 21'd6) begin
      errors++; $display("FAIL basic_stop: got busy=%b addr=%h len=%0d want 0/6/6", a_busy, wa.o_address, a_len);
    end
  endtask

  task automatic test_mid_slot_start();
    wr_t got;
    clear_logs();
    lrc = 1'b0; data = 1'b0; repeat (3) tick();
    lrc = 1'b1; data = 1'b1; repeat (6) tick();
    go();
    repeat (20) tick();
    checks++; if (qa.size() !== 0) begin errors++; $display("FAIL mid_nowrite: got %0d writes want 0", qa.size()); end
    send_frame(16'h0F0F, 16'h3C3C);
    checks++; if (qa.size() !== 2) begin errors++; $display("FAIL mid_count: got %0d want 2", qa.size()); end
    got = (qa.size() > 0) ? qa[0] : '1;
    checks++; if (got !== {20'd0, 16'h0F0F, 1'b0}) begin errors++; $display("FAIL mid_first: got a=%h d=%h c=%b want a=0 d=0f0f c=0", got.a, got.d, got.c); end
    got = (qa.size() > 1) ? qa[1] : '1;
    checks++; if (got !== {20'd1, 16'h3C3C, 1'b1}) begin errors++; $display("FAIL mid_second: got a=%h d=%h c=%b want a=1 d=3c3c c=1", got.a, got.d, got.c); end
    halt();
  endtask

  task automatic test_window_full();
    wr_t exp, got;
    clear_logs();
    idle_right(2);
    go();
    for (int k = 0; k < 6; k++) send_frame(16'(16'h1000 + k), 16'(16'hE000 + k));
    checks++; if (qb.size() !== 4) begin errors++; $display("FAIL full_count: got %0d want 4", qb.size()); end
    for (int k = 0; k < 4; k++) begin
      exp = {20'(4 + k), 16'(16'h1000 + k), 1'b0};
      got = (k < qb.size()) ? qb[k] : '1;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL full_wr%0d: got a=%h d=%h c=%b want a=%h d=%h c=%b", k, got.a, got.d, got.c, exp.a, exp.d, exp.c);
      end
    end
    checks++; if ({b_full, b_busy} !== 2'b10 || b_len !== 21'd4) begin errors++; $display("FAIL full_flags: got full=%b busy=%b len=%0d want 1/0/4", b_full, b_busy, b_len); end
    halt();
    checks++; if ({b_full, b_busy} !== 2'b00) begin errors++; $display("FAIL full_stop: got full=%b busy=%b want 0/0", b_full, b_busy); end
  endtask

  task automatic test_window_loop();
    wr_t exp, got;
    clear_logs();
    idle_right(2);
    go();
    for (int k = 0; k < 6; k++) send_frame(16'(16'h2000 + k), 16'(16'hD000 + k));
    checks++; if (qc.size() !== 6) begin errors++; $display("FAIL loop_count: got %0d want 6", qc.size()); end
    for (int k = 0; k < 6; k++) begin
      exp = {20'(4 + (k % 4)), 16'(16'h2000 + k), 1'b0};
      got = (k < qc.size()) ? qc[k] : '1;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL loop_wr%0d: got a=%h d=%h c=%b want a=%h d=%h c=%b", k, got.a, got.d, got.c, exp.a, exp.d, exp.c);
      end
    end
    checks++; if (c_len !== 21'd4 || c_busy !== 1'b1 || c_full !== 1'b0) begin errors++; $display("FAIL loop_len: got len=%0d busy=%b full=%b want 4/1/0", c_len, c_busy, c_full); end
    halt();
  endtask

  task automatic test_pause_resume();
    wr_t got;
    logic [15:0] w;
    clear_logs();
    idle_right(2);
    go();
    send_frame(16'hAAAA, 16'hBBBB);
    w = 16'h5555;
    for (int i = 0; i < 32; i++) begin
      lrc   = 1'b0;
      data  = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
      pause = (i == 8);
      tick();
    end
    pause = 1'b0;
    send_slot(1'b1, 16'h5A5A, 32);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    checks++; if (qa.size() !== 2 || a_busy !== 1'b1 || wa.o_address !== 20'd2) begin
      errors++; $display("FAIL pause_hold: got writes=%0d busy=%b addr=%h want 2/1/2", qa.size(), a_busy, wa.o_address);
    end
    go();
    send_frame(16'h7E81, 16'h0123);
    checks++; if (qa.size() !== 4) begin errors++; $display("FAIL pause_count: got %0d want 4", qa.size()); end
    got = (qa.size() > 2) ? qa[2] : '1;
    checks++; if (got !== {20'd2, 16'h7E81, 1'b0}) begin errors++; $display("FAIL pause_resume: got a=%h d=%h c=%b want a=2 d=7e81 c=0", got.a, got.d, got.c); end
    checks++; if (a_len !== 21'd4) begin errors++; $display("FAIL pause_len: got %0d want 4", a_len); end
    halt();
  endtask

  task automatic test_short_slot();
    wr_t got;
    clear_logs();
    idle_right(2);
    go();
    send_frame(16'h1111, 16'h2222);
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL short_pre: got err=%b want 0", a_err); end
    send_slot(1'b0, 16'hFFFF, 11);
    send_slot(1'b1, 16'h2468, 32);
    send_frame(16'h1357, 16'h9BDF);
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL short_err: got err=%b want 1", a_err); end
    checks++; if (qa.size() !== 5) begin errors++; $display("FAIL short_count: got %0d want 5", qa.size()); end
    got = (qa.size() > 2) ? qa[2] : '1;
    checks++; if (got !== {20'd2, 16'h2468, 1'b1}) begin errors++; $display("FAIL short_resync: got a=%h d=%h c=%b want a=2 d=2468 c=1", got.a, got.d, got.c); end
    got = (qa.size() > 3) ? qa[3] : '1;
    checks++; if (got !== {20'd3, 16'h1357, 1'b0}) begin errors++; $display("FAIL short_next: got a=%h d=%h c=%b want a=3 d=1357 c=0", got.a, got.d, got.c); end
  endtask

  task automatic test_reset_mid_slot();
    logic [15:0] w;
    w = 16'hCAFE;
    for (int i = 0; i <= 16; i++) begin
      lrc  = 1'b0;
      data = (i >= 1) ? w[16-i] : 1'b0;
      tick();
    end
    checks++; if (wa.o_we !== 1'b1 || wa.o_data !== 16'hCAFE) begin errors++; $display("FAIL rmid_due: got we=%b d=%h want 1/cafe", wa.o_we, wa.o_data); end
    rst = 1'b1;
    #1;
    checks++; if (wa.o_we !== 1'b0 || wa.o_address !== 20'd0 || wa.o_data !== 16'd0 || wa.o_ch !== 1'b0) begin
      errors++; $display("FAIL rmid_port: got we=%b a=%h d=%h c=%b want 0/0/0/0", wa.o_we, wa.o_address, wa.o_data, wa.o_ch);
    end
    checks++; if ({a_busy, a_full, a_err} !== 3'b000 || a_len !== 21'd0) begin
      errors++; $display("FAIL rmid_flags: got busy/full/err=%b len=%0d want 000/0", {a_busy, a_full, a_err}, a_len);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_mid_slot_start();
    test_window_full();
    test_window_loop();
    test_pause_resume();
    test_short_slot();
    test_reset_mid_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/aud_recorder_mc.md
Name: aud_recorder_mc

Overview:
Parametrised multi-channel I2S capture engine; successor to the single-channel 16-bit recorder. Deserialises DATA_W-bit MSB-first I2S slots for one or two channels and emits one write strobe per completed sample to the SRAM write port. Adds a configurable address window, wrap/stop-on-full mode, a sticky framing-error flag and a recorded-length output for the player.

Parameters:
DATA_W, 16, sample width in bits (8..32)
NUM_CH, 2, channels captured: 1 = left (LRC low) only, 2 = left and right
ADDR_W, 20, memory word-address width
BASE_ADDR, 0, first word address written
LAST_ADDR, 2**20-1, last word address in the window (BASE_ADDR <= LAST_ADDR)
LOOP, 0, 1 = wrap to BASE_ADDR after LAST_ADDR; 0 = stop and flag full

Ports:
i_clk  in  1  I2S bit clock; all state updates on the rising edge
i_rst  in  1  asynchronous, active-high reset
i_lrc  in  1  I2S word select: 0 = left, 1 = right
i_data  in  1  I2S serial data
i_start  in  1  start, or resume from pause (level, sampled each cycle)
i_pause  in  1  pause request
i_stop  in  1  stop request
o_we  out  1  one-cycle write strobe; o_address and o_data valid in the same cycle
o_address  out  ADDR_W  word address of the current write
o_data  out  DATA_W  captured sample
o_ch  out  1  channel of the current write (0 = left)
o_busy  out  1  high in every state except S_IDLE and S_FULL
o_full  out  1  high in S_FULL
o_err  out  1  sticky framing error; cleared by start from S_IDLE
o_len  out  ADDR_W+1  words written since the last start from S_IDLE; saturates at LAST_ADDR-BASE_ADDR+1

Behaviour:
- Reset: all outputs 0, o_address = BASE_ADDR, state S_IDLE, internal lrc_q = 0.
- LRC edge: lrc_q registers i_lrc every cycle; edge = (i_lrc != lrc_q). The MSB is the i_data sample taken on the cycle after the edge (standard I2S one-bit delay). The next DATA_W-1 cycles supply the remaining bits, MSB first.
- Slot is captured when NUM_CH = 2, or when the slot is left.
- Slot longer than DATA_W: the extra bits are ignored.
- Slot shorter than DATA_W (edge before all bits are taken): the partial word is discarded, o_err is set, and capture realigns on this edge.
- Word complete: on the cycle after the last bit, o_we = 1 with the sample and o_ch. o_address then advances by 1.
- Window end: a write at LAST_ADDR with LOOP = 0 moves the block to S_FULL. With LOOP = 1, o_address wraps to BASE_ADDR and o_len holds at its saturated value.
- Command priority: i_stop > i_pause > i_start.
- S_IDLE: on i_start, o_address = BASE_ADDR, o_len = 0, o_err = 0, go to S_ARM.
- S_ARM: wait for a falling LRC edge, which starts a left slot, so the first stored word is always left. Then go to S_SHIFT. i_pause goes to S_PAUSE; i_stop goes to S_IDLE.
- S_SHIFT: capture as above. i_pause goes to S_PAUSE immediately and discards the partial word; no o_we is issued. i_stop goes to S_IDLE immediately. An o_we already due in the same cycle as i_pause or i_stop is still issued.
- S_PAUSE: o_address and o_len are held. i_start goes to S_ARM (realigns to left). i_stop goes to S_IDLE.
- S_FULL: no writes. i_stop goes to S_IDLE; i_start is ignored.
- S_IDLE after a stop keeps o_address, o_len and o_err for readback until the next start.
- Asynchronous reset mid-slot: the block returns to the reset state in the same cycle; no o_we is issued.

Decomposition:
- aud_pkg: state enum (S_IDLE, S_ARM, S_SHIFT, S_PAUSE, S_FULL) and channel constants CH_L = 0, CH_R = 1.
- Sub-module i2s_deser, parametrised by DATA_W. It holds the LRC edge detect, bit counter and MSB-first shift register. Its outputs are word_valid, word, word_ch and short_err, and it takes an enable input.
- The parent holds the FSM, address window and length logic.

Test Plan:
1. NUM_CH = 2, DATA_W = 16, 32-bit slots, left = 0xA5C3, right = 0x1234 for 3 frames after start -> 6 o_we pulses, addresses 0..5, data alternating A5C3/1234, o_ch = 0,1,…, o_len = 6.
2. Start asserted mid right slot -> no write until the next falling LRC edge; the first write has o_ch = 0 at BASE_ADDR.
3. LOOP = 0, BASE_ADDR = 4, LAST_ADDR = 7, NUM_CH = 1 -> writes at 4,5,6,7, then o_full = 1 and o_busy = 0. Further frames produce no o_we. Stop returns to idle.
4. LOOP = 1, same window, 6 left samples -> addresses 4,5,6,7,4,5; o_len saturates at 4.
5. Pause asserted at bit 8 of a left slot, start after 2 frames -> no write for the interrupted slot; the next write is the next left sample at the held address.
6. LRC toggles after 10 bits with DATA_W = 16 -> o_err = 1 and no write for that slot; capture resumes correctly on the following slot. Reset asserted mid-slot -> all outputs 0 and o_address = BASE_ADDR immediately.
